// File: rtl/line_mem_responder_if.sv
// Line memory request/response bus between a requester and line_mem_responder.
// proto_err exists only when MEM_PROTO_CHECK_EN is defined.
interface line_mem_responder_if;
    logic        re;
    logic        we;
    logic [13:0] addr;
    logic [63:0] wdata;
    logic        rdy;
    logic [63:0] rdata;
    logic        busy;
`ifdef MEM_PROTO_CHECK_EN
    logic        proto_err;

    modport master (
        output re, we, addr, wdata,
        input  rdy, rdata, busy, proto_err
    );
    modport slave (
        input  re, we, addr, wdata,
        output rdy, rdata, busy, proto_err
    );
`else
    modport master (
        output re, we, addr, wdata,
        input  rdy, rdata, busy
    );
    modport slave (
        input  re, we, addr, wdata,
        output rdy, rdata, busy
    );
`endif
endinterface

// File: rtl/line_mem_responder.sv
// Fixed-latency 64-bit line memory: one request at a time, rdy pulse LAT cycles after acceptance.
// Optional MEM_PROTO_CHECK_EN adds a sticky proto_err flag for request-protocol violations.
module line_mem_responder #(
    parameter int unsigned LAT   = 4,
    parameter int unsigned DEPTH = 16384
) (
    input logic                 clk,
    input logic                 rst,
    line_mem_responder_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic        op_we_q;
    logic [13:0] addr_q;
    logic [63:0] wdata_q;
    logic        rdy_q;
    logic        busy_q;
    logic [63:0] rdata_q;
    logic [63:0] mem [DEPTH];

    logic          accept;
    logic          go_resp;
    logic          cur_we;
    logic [13:0]   cur_addr;
    logic [63:0]   cur_wdata;
    logic [AW-1:0] idx;

    // With LAT=1 the access happens on the accepting edge, so use the live inputs.
    always_comb begin
        accept    = (state_q == StIdle) && (bus.re || bus.we);
        go_resp   = (accept && (LAT == 1)) || ((state_q == StBusy) && (cnt_q == 8'd0));
        cur_we    = accept ? bus.we    : op_we_q;
        cur_addr  = accept ? bus.addr  : addr_q;
        cur_wdata = accept ? bus.wdata : wdata_q;
        idx       = cur_addr[AW-1:0];
    end

    // Array has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && go_resp && cur_we) begin
            mem[idx] <= cur_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            op_we_q <= 1'b0;
            addr_q  <= 14'd0;
            wdata_q <= 64'd0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= 64'd0;
        end else begin
            rdy_q <= go_resp;
            if (go_resp && !cur_we) begin
                rdata_q <= mem[idx];
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_we_q <= bus.we;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        busy_q  <= 1'b1;
                        if (LAT == 1) begin
                            state_q <= StResp;
                        end else begin
                            state_q <= StBusy;
                            cnt_q   <= 8'(LAT - 2);
                        end
                    end
                end
                StBusy: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rdy   = rdy_q;
    assign bus.busy  = busy_q;
    assign bus.rdata = rdata_q;

`ifdef MEM_PROTO_CHECK_EN
    logic proto_err_q;

    // Both ops at once in IDLE, or the address moving under an outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err_q <= 1'b0;
        end else if (((state_q == StIdle) && bus.re && bus.we) ||
                     ((state_q == StBusy) && (bus.re || bus.we) && (bus.addr != addr_q))) begin
            proto_err_q <= 1'b1;
        end
    end

    assign bus.proto_err = proto_err_q;
`endif
endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: three instances cover LAT=4, LAT=1 and a DEPTH=1024 wrap.
module tb_line_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   failed = 0;

    localparam logic [63:0] DA = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] VA = 64'h0A0A_0A0A_1111_2222;
    localparam logic [63:0] VB = 64'hB0B0_3333_4444_5555;
    localparam logic [63:0] VC = 64'hC0C0_6666_7777_8888;
    localparam logic [63:0] VD = 64'hD0D0_9999_AAAA_BBBB;
    localparam logic [63:0] VE = 64'hE0E0_1234_5678_9ABC;
    localparam logic [63:0] VF = 64'hF0F0_0F0F_F0F0_0F0F;
    localparam logic [63:0] VG = 64'h6060_ABCD_EF01_2345;

    always #5 clk = ~clk;

    line_mem_responder_if b4 ();
    line_mem_responder_if b1 ();
    line_mem_responder_if bd ();

    line_mem_responder #(.LAT(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
    line_mem_responder #(.LAT(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    line_mem_responder #(.LAT(2), .DEPTH(1024)) ud (.clk(clk), .rst(rst), .bus(bd.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        b4.re = 1'b0; b4.we = 1'b0; b4.addr = 14'd0; b4.wdata = 64'd0;
        b1.re = 1'b0; b1.we = 1'b0; b1.addr = 14'd0; b1.wdata = 64'd0;
        bd.re = 1'b0; bd.we = 1'b0; bd.addr = 14'd0; bd.wdata = 64'd0;

        // Reset state, and a request held during reset is ignored until rst drops.
        tick(); tick();
        chk1("rst_rdy", b4.rdy, 1'b0);
        chk1("rst_busy", b4.busy, 1'b0);
        chk64("rst_rdata", b4.rdata, 64'd0);
        chk1("rst_busy_lat1", b1.busy, 1'b0);
`ifdef MEM_PROTO_CHECK_EN
        chk1("rst_proto_err", b4.proto_err, 1'b0);
`endif
        b4.re = 1'b1; b4.addr = 14'h0020;
        tick();
        chk1("req_in_rst_ignored", b4.busy, 1'b0);
        rst = 1'b0;
        tick();
        chk1("accept_after_rst", b4.busy, 1'b1);
        b4.re = 1'b0;
        tick(); tick(); tick();
        chk1("first_read_rdy", b4.rdy, 1'b1);
        tick();

        // LAT=4 write then read of 0x0010.
        b4.we = 1'b1; b4.addr = 14'h0010; b4.wdata = DA;
        tick();
        b4.we = 1'b0;
        chk1("wr_c1_busy", b4.busy, 1'b1);
        chk1("wr_c1_rdy", b4.rdy, 1'b0);
        tick(); tick();
        chk1("wr_c3_rdy", b4.rdy, 1'b0);
        tick();
        chk1("wr_c4_rdy", b4.rdy, 1'b1);
        chk1("wr_c4_busy", b4.busy, 1'b1);
        tick();
        chk1("c5_busy", b4.busy, 1'b0);
        chk1("c5_rdy", b4.rdy, 1'b0);
        b4.re = 1'b1; b4.addr = 14'h0010;
        tick();
        b4.re = 1'b0; b4.addr = 14'h0011;
        chk1("rd_c6_busy", b4.busy, 1'b1);
        tick(); tick();
        chk1("rd_c8_rdy", b4.rdy, 1'b0);
        tick();
        chk1("rd_c9_rdy", b4.rdy, 1'b1);
        chk64("rd_c9_rdata", b4.rdata, DA);
        tick();
        chk1("rd_c10_rdy", b4.rdy, 1'b0);
        chk64("rd_c10_rdata_hold", b4.rdata, DA);

        // Write A to 5, read it back-to-back, then write B to 6 leaves rdata=A.
        b4.we = 1'b1; b4.addr = 14'h0005; b4.wdata = VA;
        tick();
        b4.we = 1'b0;
        tick(); tick(); tick();
        chk1("wa_rdy", b4.rdy, 1'b1);
        tick();
        b4.re = 1'b1; b4.addr = 14'h0005;
        tick();
        b4.re = 1'b0;
        tick(); tick(); tick();
        chk1("b2b_rdy", b4.rdy, 1'b1);
        chk64("b2b_rdata", b4.rdata, VA);
        tick();
        b4.we = 1'b1; b4.addr = 14'h0006; b4.wdata = VB;
        tick();
        b4.we = 1'b0;
        tick(); tick(); tick();
        chk1("wb_rdy", b4.rdy, 1'b1);
        chk64("wb_rdata_hold", b4.rdata, VA);
        tick();

        // Write C to 0x20, then abort a write of D with reset in C2.
        b4.we = 1'b1; b4.addr = 14'h0020; b4.wdata = VC;
        tick();
        b4.we = 1'b0;
        tick(); tick(); tick(); tick();
        b4.we = 1'b1; b4.addr = 14'h0020; b4.wdata = VD;
        tick();
        b4.we = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("abort_busy", b4.busy, 1'b0);
        chk1("abort_rdy", b4.rdy, 1'b0);
        chk64("abort_rdata", b4.rdata, 64'd0);
        tick();
        chk1("abort_no_rdy", b4.rdy, 1'b0);
        chk1("abort_busy2", b4.busy, 1'b0);
        b4.re = 1'b1; b4.addr = 14'h0020;
        tick();
        b4.re = 1'b0;
        tick(); tick(); tick();
        chk1("abort_rd_rdy", b4.rdy, 1'b1);
        chk64("abort_rd_rdata", b4.rdata, VC);
        tick();

        // re and we together: write wins.
        b4.re = 1'b1; b4.we = 1'b1; b4.addr = 14'h0003; b4.wdata = VE;
        tick();
        b4.re = 1'b0; b4.we = 1'b0;
`ifdef MEM_PROTO_CHECK_EN
        chk1("both_proto_err", b4.proto_err, 1'b1);
`endif
        tick(); tick(); tick();
        chk1("both_rdy", b4.rdy, 1'b1);
        tick();
        b4.re = 1'b1; b4.addr = 14'h0003;
        tick();
        b4.re = 1'b0;
        tick(); tick(); tick();
        chk64("both_rd_rdata", b4.rdata, VE);
`ifdef MEM_PROTO_CHECK_EN
        chk1("proto_err_sticky", b4.proto_err, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("proto_err_rst", b4.proto_err, 1'b0);
`endif
        tick();

        // LAT=1: write F to 7, then a held read completes every other cycle.
        b1.we = 1'b1; b1.addr = 14'h0007; b1.wdata = VF;
        tick();
        b1.we = 1'b0;
        chk1("l1_wr_rdy", b1.rdy, 1'b1);
        chk1("l1_wr_busy", b1.busy, 1'b1);
        tick();
        chk1("l1_idle_rdy", b1.rdy, 1'b0);
        chk1("l1_idle_busy", b1.busy, 1'b0);
        b1.re = 1'b1; b1.addr = 14'h0007;
        tick();
        chk1("l1_rd1_rdy", b1.rdy, 1'b1);
        chk64("l1_rd1_rdata", b1.rdata, VF);
        tick();
        chk1("l1_gap_rdy", b1.rdy, 1'b0);
        chk1("l1_gap_busy", b1.busy, 1'b0);
        chk64("l1_gap_rdata", b1.rdata, VF);
        tick();
        chk1("l1_rd2_rdy", b1.rdy, 1'b1);
        chk64("l1_rd2_rdata", b1.rdata, VF);
        b1.re = 1'b0;
        tick();
        chk1("l1_end_rdy", b1.rdy, 1'b0);

        // DEPTH=1024, LAT=2: 0x401 aliases 0x001.
        bd.we = 1'b1; bd.addr = 14'h0401; bd.wdata = VG;
        tick();
        bd.we = 1'b0;
        chk1("wrap_wr_c1_rdy", bd.rdy, 1'b0);
        chk1("wrap_wr_c1_busy", bd.busy, 1'b1);
        tick();
        chk1("wrap_wr_rdy", bd.rdy, 1'b1);
        tick();
        bd.re = 1'b1; bd.addr = 14'h0001;
        tick();
        bd.re = 1'b0;
        tick();
        chk1("wrap_rd_rdy", bd.rdy, 1'b1);
        chk64("wrap_rd_rdata", bd.rdata, VG);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/line_mem_responder.md
LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

Interface
REQ-001 Parameter LAT, default 4: cycles from request acceptance to rdy pulse; legal range 1..255.
REQ-002 Parameter DEPTH, default 16384: number of 64-bit lines; SHALL be a power of two, at most 2^14.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-high.
REQ-005 Port re  input  1  line read request.
REQ-006 Port we  input  1  line write request.
REQ-007 Port addr  input  14  line address (word address [15:2]).
REQ-008 Port wdata  input  64  write line data.
REQ-009 Port rdy  output  1  one-cycle completion pulse, for reads and for writes.
REQ-010 Port rdata  output  64  read line data; valid from the rdy cycle until the next read completes.
REQ-011 Port busy  output  1  high while a request is outstanding (BUSY or RESP state).
REQ-012 Port proto_err  output  1  sticky protocol-error flag; present only under MEM_PROTO_CHECK_EN.

Function
REQ-013 The block SHALL implement three states: IDLE, BUSY and RESP.
REQ-014 In IDLE, if re|we is high at a clock edge, the block SHALL accept the request: it latches addr, wdata and op (we has priority over re when both are high).
REQ-015 On acceptance, the block SHALL go to RESP when LAT=1; otherwise it goes to BUSY and loads a down-counter with LAT-2.
REQ-016 In BUSY, the block SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 0.
REQ-017 rdy SHALL be registered and high only in RESP, for exactly one cycle. A request sampled in cycle C0 yields rdy in cycle C0+LAT.
REQ-018 A write SHALL update array[latched addr mod DEPTH] on the edge entering RESP.
REQ-019 A read SHALL load rdata from array[latched addr mod DEPTH] on the edge entering RESP.
REQ-020 rdata SHALL hold its value through writes and idle cycles.
REQ-021 RESP SHALL always return to IDLE on the next edge.
REQ-022 re/we/addr/wdata SHALL be ignored in BUSY and RESP; a request held through rdy is not re-accepted until the IDLE cycle that follows.
REQ-023 Back-to-back operation SHALL be supported: a request in the IDLE cycle immediately after RESP is accepted. A read there returns data written by the just-completed write.
REQ-024 The latched address SHALL be used throughout the operation; addr changes after acceptance SHALL have no effect.
REQ-025 busy SHALL be high in BUSY and RESP and low in IDLE.

Reset
REQ-026 With rst high at an edge, the block SHALL go to IDLE, with rdy=0, busy=0, rdata=0, counter=0 and proto_err=0.
REQ-027 Reset mid-operation SHALL abort the operation: no array write and no rdy pulse.
REQ-028 Array contents SHALL NOT be cleared by reset.
REQ-029 Requests present during reset SHALL be ignored; acceptance starts on the first edge with rst low.

Configuration
REQ-030 Macro MEM_PROTO_CHECK_EN defined: port proto_err SHALL exist and be set when re&we are both high in IDLE, or when addr differs from the latched address while re|we is high in BUSY. It clears only on reset.
REQ-031 Macro MEM_PROTO_CHECK_EN undefined: the proto_err port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 LAT=4: write addr=0x0010, wdata=0xDEAD_BEEF_0123_4567 in C0 -> rdy only in C4, busy C1..C4; read addr=0x0010 issued in C5 -> rdy in C9 with rdata=0xDEAD_BEEF_0123_4567.
REQ-033 LAT=1: read in C0, held high -> rdy in C1, request re-accepted in C2, rdy in C3; rdata stable between pulses.
REQ-034 Write addr=0x0005 data A, then read addr=0x0005 in the IDLE cycle right after rdy -> rdata=A; a later write of B to 0x0006 leaves rdata=A.
REQ-035 LAT=4: rst asserted in C2 of a write to 0x0020 -> no rdy, busy=0 in the cycle after reset; a subsequent read of 0x0020 returns the pre-write contents.
REQ-036 re and we both high with addr=0x0003 -> write performed. With MEM_PROTO_CHECK_EN: proto_err=1 from the next cycle until rst; without it: no proto_err port.
REQ-037 DEPTH=1024: write to addr=0x0401 -> read of addr=0x0001 returns that data (modulo wrap).
